bisr_job_scheduler: RTL and testbench

Job-level controller in front of bisr_systolic_top. It accepts matmul jobs from the host over a valid/ready handshake and sequences start_fsm/fsm_rdy/fsm_done. It decides per job whether to run a Stop-the-World self-test, which it does by asserting bisr_en. It accumulates STW_result_mat into a persistent fault map, checks repairability against the one-proxy-per-column limit, and guards every job with a watchdog.

---
 rtl/bisr_job_scheduler_pkg.sv | 29 ++
 rtl/bisr_job_scheduler_if.sv | 42 ++++
 rtl/bisr_fault_map.sv | 54 +++++
 rtl/bisr_job_scheduler.sv | 136 +++++++++++++
 tb/tb_bisr_job_scheduler.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/bisr_job_scheduler_pkg.sv
// Shared types and width helpers for the BISR job scheduler.
package bisr_sched_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    ISSUE    = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4,
    HALT     = 3'd5
  } sched_state_e;

  // Width of a popcount over a given number of PE flags.
  function automatic int unsigned fault_cnt_w(input int unsigned cells);
    return $clog2(cells + 1);
  endfunction

  // Width of a watchdog that counts 0 .. timeout-1.
  function automatic int unsigned wdog_w(input int unsigned timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

  localparam int unsigned DEF_ROWS    = 4;
  localparam int unsigned DEF_COLS    = 4;
  localparam int unsigned DEF_TIMEOUT = 4096;
  localparam int unsigned FAULT_CNT_W = fault_cnt_w(DEF_ROWS * DEF_COLS);
  localparam int unsigned WDOG_W      = wdog_w(DEF_TIMEOUT);

endpackage

// File: rtl/bisr_job_scheduler_if.sv
// Host job handshake plus the control/status link to the systolic top.
interface bisr_job_scheduler_if
  import bisr_sched_pkg::*;
#(
  parameter int unsigned ROWS = DEF_ROWS,
  parameter int unsigned COLS = DEF_COLS
);
  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned FC_W  = fault_cnt_w(CELLS);

  logic             job_valid;
  logic             job_ready;
  logic             force_test;
  logic             clear_faults;
  logic             job_done;
  logic             job_err;
  logic             start_fsm;
  logic             bisr_en;
  logic             fsm_rdy;
  logic             fsm_done;
  logic             STW_complete;
  logic [CELLS-1:0] STW_result_mat;
  logic [CELLS-1:0] fault_map;
  logic [FC_W-1:0]  fault_count;
  logic             unrepairable;
  logic             timeout;
  logic [2:0]       sched_state;

  modport master (
    output job_valid, force_test, clear_faults, fsm_rdy, fsm_done,
           STW_complete, STW_result_mat,
    input  job_ready, job_done, job_err, start_fsm, bisr_en, fault_map,
           fault_count, unrepairable, timeout, sched_state
  );

  modport slave (
    input  job_valid, force_test, clear_faults, fsm_rdy, fsm_done,
           STW_complete, STW_result_mat,
    output job_ready, job_done, job_err, start_fsm, bisr_en, fault_map,
           fault_count, unrepairable, timeout, sched_state
  );
endinterface

// File: rtl/bisr_fault_map.sv
// Persistent PE fault map with registered popcount and column repairability.
module bisr_fault_map
  import bisr_sched_pkg::*;
#(
  parameter int unsigned ROWS = DEF_ROWS,
  parameter int unsigned COLS = DEF_COLS
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 accumulate,
  input  logic                                 clear,
  input  logic [ROWS*COLS-1:0]                 stw_result,
  output logic [ROWS*COLS-1:0]                 fault_map,
  output logic [fault_cnt_w(ROWS*COLS)-1:0]    fault_count,
  output logic                                 unrepairable
);
  localparam int unsigned FC_W = fault_cnt_w(ROWS * COLS);

  logic [FC_W-1:0] count_next;
  logic            unrep_next;

  // Fault flags only ever accumulate until an explicit clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            fault_map <= '0;
    else if (clear)      fault_map <= '0;
    else if (accumulate) fault_map <= fault_map | stw_result;
  end

  // Total popcount and "two or more faults in one column" check.
  always_comb begin
    logic [FC_W-1:0] col_cnt;
    count_next = '0;
    unrep_next = 1'b0;
    col_cnt    = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      col_cnt = '0;
      for (int unsigned r = 0; r < ROWS; r++)
        col_cnt = col_cnt + FC_W'(fault_map[c*ROWS + r]);
      count_next = count_next + col_cnt;
      if (col_cnt >= FC_W'(2)) unrep_next = 1'b1;
    end
  end

  // Status lags fault_map by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_count  <= '0;
      unrepairable <= 1'b0;
    end else begin
      fault_count  <= count_next;
      unrepairable <= unrep_next;
    end
  end
endmodule

// File: rtl/bisr_job_scheduler.sv
// Job-level sequencer for the BISR systolic array: self-test scheduling,
// fault accumulation and a per-job watchdog.
module bisr_job_scheduler
  import bisr_sched_pkg::*;
#(
  parameter int unsigned ROWS           = DEF_ROWS,
  parameter int unsigned COLS           = DEF_COLS,
  parameter int unsigned TEST_INTERVAL  = 4,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  bisr_job_scheduler_if.slave   bus
);
  localparam int unsigned WD_W  = wdog_w(TIMEOUT_CYCLES);
  localparam int unsigned CNT_W = (TEST_INTERVAL > 1) ? $clog2(TEST_INTERVAL) : 1;

  sched_state_e          state, state_next;
  logic [WD_W-1:0]       wdog;
  logic [CNT_W-1:0]      job_cnt;
  logic                  test_job, test_pending, first_job_done, stw_seen;
  logic                  bisr_en, timeout, halt_ack;
  logic                  job_ready, start_fsm, job_done, job_err;
  logic                  accept, test_job_next, accumulate, clear, wdog_expired;
  logic [ROWS*COLS-1:0]  fault_map;
  logic                  unrepairable;

  assign accept        = bus.job_valid && (state == IDLE);
  assign test_job_next = !first_job_done || (job_cnt == CNT_W'(TEST_INTERVAL - 1)) ||
                         test_pending || bus.force_test;
  assign accumulate    = (state == RUN) && bus.STW_complete && test_job;
  assign clear         = (state == IDLE) && bus.clear_faults;
  assign wdog_expired  = (wdog == WD_W'(TIMEOUT_CYCLES - 1));

  bisr_fault_map #(.ROWS(ROWS), .COLS(COLS)) u_fault_map (
    .clk          (clk),
    .rst          (rst),
    .accumulate   (accumulate),
    .clear        (clear),
    .stw_result   (bus.STW_result_mat),
    .fault_map    (fault_map),
    .fault_count  (bus.fault_count),
    .unrepairable (unrepairable)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_next = state;
    job_ready  = 1'b0;
    start_fsm  = 1'b0;
    job_done   = 1'b0;
    job_err    = 1'b0;
    case (state)
      IDLE: begin
        job_ready = 1'b1;
        if (bus.job_valid) state_next = WAIT_RDY;
      end
      WAIT_RDY: if (bus.fsm_rdy) state_next = ISSUE;
      ISSUE: begin
        start_fsm  = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (bus.fsm_done)       state_next = DONE;
        else if (wdog_expired)  state_next = HALT;
      end
      DONE: begin
        job_done   = 1'b1;
        job_err    = unrepairable || (test_job && !stw_seen);
        state_next = IDLE;
      end
      HALT: begin
        job_done = !halt_ack;
        job_err  = !halt_ack;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job bookkeeping: test selection, interval counter, watchdog, sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      test_job       <= 1'b0;
      test_pending   <= 1'b0;
      first_job_done <= 1'b0;
      job_cnt        <= '0;
      wdog           <= '0;
      stw_seen       <= 1'b0;
      timeout        <= 1'b0;
      halt_ack       <= 1'b0;
    end else begin
      if (accept) test_job <= test_job_next;
      if (accept && test_job_next) test_pending <= 1'b0;
      else if (bus.force_test)     test_pending <= 1'b1;
      if (state == ISSUE)    wdog <= '0;
      else if (state == RUN) wdog <= wdog + WD_W'(1);
      if (state == ISSUE || state == DONE) stw_seen <= 1'b0;
      else if (accumulate)                 stw_seen <= 1'b1;
      // The power-on test job sits outside the interval count, so periodic
      // tests land on jobs 1, 1+TEST_INTERVAL, 1+2*TEST_INTERVAL, ...
      if (state == DONE) begin
        first_job_done <= 1'b1;
        if (first_job_done)
          job_cnt <= (job_cnt == CNT_W'(TEST_INTERVAL - 1)) ? '0 : job_cnt + CNT_W'(1);
      end
      if (state == RUN && !bus.fsm_done && wdog_expired) timeout <= 1'b1;
      halt_ack <= (state == HALT);
    end
  end

  // Repair/self-test enable, frozen from ISSUE until RUN exits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bisr_en <= 1'b0;
    else if (state == WAIT_RDY && bus.fsm_rdy)
      bisr_en <= test_job || ((|fault_map) && !unrepairable);
    else if (state == RUN && state_next != RUN)
      bisr_en <= 1'b0;
  end

  assign bus.job_ready    = job_ready;
  assign bus.start_fsm    = start_fsm;
  assign bus.job_done     = job_done;
  assign bus.job_err      = job_err;
  assign bus.bisr_en      = bisr_en;
  assign bus.timeout      = timeout;
  assign bus.fault_map    = fault_map;
  assign bus.unrepairable = unrepairable;
  assign bus.sched_state  = state;
endmodule

// File: tb/tb_bisr_job_scheduler.sv
// Directed self-checking bench for bisr_job_scheduler (4x4, interval 4, timeout 64).
module tb_bisr_job_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_pulses = 0;
  int   start_pulses = 0;
  int   bad_start = 0;

  always #5 clk = ~clk;

  bisr_job_scheduler_if #(.ROWS(4), .COLS(4)) bus ();

  bisr_job_scheduler #(
    .ROWS(4), .COLS(4), .TEST_INTERVAL(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) begin
    if (bus.job_done) done_pulses++;
    if (bus.start_fsm) begin
      start_pulses++;
      if (bus.sched_state != 3'd2) bad_start++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.job_valid = 1'b0; bus.force_test = 1'b0; bus.clear_faults = 1'b0;
    bus.fsm_done = 1'b0; bus.STW_complete = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One job: stw_at/done_at/force_at/clear_at are RUN-cycle indices (-1 = never).
  task automatic do_job(input logic [15:0] res, input int stw_at, input int done_at,
                        input int force_at, input int clear_at,
                        output logic en, output logic err, output int lat, output logic got);
    logic started;
    en = 1'b0; err = 1'b0; lat = -1; got = 1'b0; started = 1'b0;
    bus.STW_result_mat = res;
    @(posedge clk); #1 bus.job_valid = 1'b1;
    @(posedge clk); #1 bus.job_valid = 1'b0;
    for (int i = 0; i < 20 && !started; i++) begin
      @(negedge clk);
      if (bus.start_fsm) begin
        started = 1'b1;
        en = bus.bisr_en;
      end
    end
    chk("start_seen", 32'(started), 1);
    for (int k = 0; k < 100 && !got; k++) begin
      @(posedge clk); #1;
      bus.STW_complete = (k == stw_at);
      bus.fsm_done     = (k == done_at);
      bus.force_test   = (k == force_at);
      bus.clear_faults = (k == clear_at);
      @(negedge clk);
      if (bus.job_done) begin
        got = 1'b1;
        err = bus.job_err;
        lat = k;
      end
    end
    bus.STW_complete = 1'b0; bus.fsm_done = 1'b0;
    bus.force_test = 1'b0; bus.clear_faults = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic en, err, got;
    int   lat, dp0, sp0;
    logic [15:0] res;

    bus.job_valid = 1'b0; bus.force_test = 1'b0; bus.clear_faults = 1'b0;
    bus.fsm_rdy = 1'b1; bus.fsm_done = 1'b0; bus.STW_complete = 1'b0;
    bus.STW_result_mat = '0;

    // Reset values while rst is held low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state",   32'(bus.sched_state), 0);
    chk("rst_ready",   32'(bus.job_ready), 1);
    chk("rst_bisr_en", 32'(bus.bisr_en), 0);
    chk("rst_start",   32'(bus.start_fsm), 0);
    chk("rst_done",    32'(bus.job_done), 0);
    chk("rst_fmap",    32'(bus.fault_map), 0);
    chk("rst_fcount",  32'(bus.fault_count), 0);
    chk("rst_unrep",   32'(bus.unrepairable), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    @(posedge clk); #1 rst = 1'b1;

    // Five clean jobs: tests on 1 and 5; non-test STW on job 2 is ignored.
    for (int j = 1; j <= 5; j++) begin
      res = (j == 2) ? 16'h8000 : 16'h0000;
      do_job(res, 3, 9, -1, -1, en, err, lat, got);
      chk($sformatf("A%0d_done", j),    32'(got), 1);
      chk($sformatf("A%0d_bisr_en", j), 32'(en), (j == 1 || j == 5) ? 1 : 0);
      chk($sformatf("A%0d_err", j),     32'(err), 0);
      chk($sformatf("A%0d_lat", j),     32'(lat), 10);
    end
    @(negedge clk);
    chk("A_fmap",   32'(bus.fault_map), 0);
    chk("A_pulses", 32'(done_pulses), 5);
    chk("A_starts", 32'(start_pulses), 5);

    // Fault accumulation across two test jobs; faults keep bisr_en on.
    do_reset();
    for (int j = 1; j <= 5; j++) begin
      res = (j == 1) ? 16'h0001 : (j == 5) ? 16'h0010 : 16'h0000;
      do_job(res, 3, 9, -1, -1, en, err, lat, got);
      chk($sformatf("B%0d_bisr_en", j), 32'(en), 1);
      chk($sformatf("B%0d_err", j),     32'(err), 0);
    end
    @(negedge clk);
    chk("B_fmap",   32'(bus.fault_map), 32'h0011);
    chk("B_fcount", 32'(bus.fault_count), 2);
    chk("B_unrep",  32'(bus.unrepairable), 0);

    // force_test mid-job 6 makes job 7 a test; column 0 gets two faults.
    do_job(16'h0000, 3, 9, 4, -1, en, err, lat, got);
    chk("C6_bisr_en", 32'(en), 1);
    chk("C6_err",     32'(err), 0);
    do_job(16'h0003, 3, 9, -1, -1, en, err, lat, got);
    chk("C7_bisr_en", 32'(en), 1);
    chk("C7_err",     32'(err), 1);
    @(negedge clk);
    chk("C7_fmap",   32'(bus.fault_map), 32'h0013);
    chk("C7_fcount", 32'(bus.fault_count), 3);
    chk("C7_unrep",  32'(bus.unrepairable), 1);
    // Job 8: unrepairable suppresses bisr_en; clear_faults during RUN is ignored.
    do_job(16'h0000, 3, 9, -1, 5, en, err, lat, got);
    chk("C8_bisr_en", 32'(en), 0);
    chk("C8_err",     32'(err), 1);
    chk("C8_fmap",    32'(bus.fault_map), 32'h0013);
    @(posedge clk); #1 bus.clear_faults = 1'b1;
    @(posedge clk); #1 bus.clear_faults = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("C_clr_fmap",   32'(bus.fault_map), 0);
    chk("C_clr_fcount", 32'(bus.fault_count), 0);
    chk("C_clr_unrep",  32'(bus.unrepairable), 0);
    // Job 9: interval test with no STW_complete -> error.
    do_job(16'h0000, -1, 9, -1, -1, en, err, lat, got);
    chk("C9_bisr_en", 32'(en), 1);
    chk("C9_err",     32'(err), 1);
    // force_test in IDLE; job 10 gets STW_complete and fsm_done together.
    @(posedge clk); #1 bus.force_test = 1'b1;
    @(posedge clk); #1 bus.force_test = 1'b0;
    do_job(16'h0100, 9, 9, -1, -1, en, err, lat, got);
    chk("C10_bisr_en", 32'(en), 1);
    chk("C10_err",     32'(err), 0);
    @(negedge clk);
    chk("C10_fmap",   32'(bus.fault_map), 32'h0100);
    chk("C10_fcount", 32'(bus.fault_count), 1);

    // fsm_done on the terminal watchdog cycle still completes normally.
    do_job(16'h0000, -1, 63, -1, -1, en, err, lat, got);
    chk("D11_done",    32'(got), 1);
    chk("D11_err",     32'(err), 0);
    chk("D11_lat",     32'(lat), 64);
    chk("D11_bisr_en", 32'(en), 1);
    @(negedge clk);
    chk("D11_timeout", 32'(bus.timeout), 0);
    chk("D11_state",   32'(bus.sched_state), 0);
    // No fsm_done: watchdog expires into HALT.
    dp0 = done_pulses;
    sp0 = start_pulses;
    do_job(16'h0000, -1, -1, -1, -1, en, err, lat, got);
    chk("D12_done",    32'(got), 1);
    chk("D12_err",     32'(err), 1);
    chk("D12_lat",     32'(lat), 64);
    chk("D12_timeout", 32'(bus.timeout), 1);
    chk("D12_state",   32'(bus.sched_state), 5);
    chk("D12_bisr_en", 32'(bus.bisr_en), 0);
    @(posedge clk); #1 bus.job_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.job_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("H_pulses",  32'(done_pulses), 32'(dp0 + 1));
    chk("H_starts",  32'(start_pulses), 32'(sp0 + 1));
    chk("H_state",   32'(bus.sched_state), 5);
    chk("H_ready",   32'(bus.job_ready), 0);
    chk("H_timeout", 32'(bus.timeout), 1);

    // Reset recovers from HALT; then reset again in the middle of RUN.
    do_reset();
    @(negedge clk);
    chk("E_state",   32'(bus.sched_state), 0);
    chk("E_timeout", 32'(bus.timeout), 0);
    chk("E_ready",   32'(bus.job_ready), 1);
    bus.STW_result_mat = '0;
    @(posedge clk); #1 bus.job_valid = 1'b1;
    @(posedge clk); #1 bus.job_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("E_run_state", 32'(bus.sched_state), 3);
    chk("E_run_bisr",  32'(bus.bisr_en), 1);
    #2 rst = 1'b0;
    #1;
    chk("E_async_start", 32'(bus.start_fsm), 0);
    chk("E_async_bisr",  32'(bus.bisr_en), 0);
    chk("E_async_state", 32'(bus.sched_state), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("E_post_state", 32'(bus.sched_state), 0);
    chk("E_post_ready", 32'(bus.job_ready), 1);
    chk("start_in_issue_only", 32'(bad_start), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
